spi_slave_shifter: RTL and testbench
====================================

// Module: spi_slave_shifter
// PURPOSE
//  SPI responder-side (slave) shifter: the far end of our SPI master shift register.
//  Oversamples external sclk/ss_n/mosi in the PCLK domain, deserialises mosi into rx bytes, serialises tx bytes onto miso.
//  Supports all four CPOL/CPHA modes and MSB/LSB-first ordering; sits between the SPI pads and the slave APB register block.
// PARAMETERS
//  DATA_WIDTH   8   bits per SPI word
//  SYNC_STAGES  2   synchroniser flops on sclk, ss_n, mosi (>=2)
// PORTS
//  PCLK       in   1           system clock; all logic on posedge
//  PRESET     in   1           synchronous, active-high reset
//  sclk       in   1           SPI serial clock from master (asynchronous)
//  ss_n       in   1           slave select, active-low (asynchronous)
//  mosi       in   1           serial data from master
//  miso       out  1           serial data to master
//  miso_oe    out  1           miso output enable (pad tristate control)
//  cpol, cpha in   1           SPI mode; sampled only in IDLE
//  lsbfe      in   1           1 = LSB first, 0 = MSB first; sampled only in IDLE
//  tx_data    in   DATA_WIDTH  next word to transmit
//  tx_load    in   1           1-cycle strobe: write tx_data into tx holding reg
//  tx_empty   out  1           holding reg free (may load)
//  rx_data    out  DATA_WIDTH  last complete received word
//  rx_valid   out  1           rx_data valid; held until rx_ack
//  rx_ack     in   1           consumer strobe; clears rx_valid
//  overrun    out  1           1-cycle pulse: word completed while rx_valid still high
//  underrun   out  1           1-cycle pulse: word started with tx holding reg empty
//  busy       out  1           high in ACTIVE
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, tx_empty=1, rx_data=0, rx_valid=0, overrun=0, underrun=0, busy=0, state IDLE, bit count 0.
//   PRESET mid-frame aborts immediately; partial word discarded.
//  Sync: sclk/ss_n/mosi pass SYNC_STAGES flops; edges found against one extra sclk flop -> action SYNC_STAGES+1 PCLKs after pin edge.
//   Requires PCLK >= 8x sclk; no behaviour defined below that.
//  Leading edge = rising if cpol=0, falling if cpol=1. Sample mosi: leading edge if cpha=0, trailing if cpha=1.
//   Shift out: trailing edge if cpha=0, leading edge if cpha=1.
//  FSM IDLE: miso_oe=0. On synced ss_n 1->0: latch cpol/cpha/lsbfe, load shift-out reg from holding reg, tx_empty<=1,
//   goto ACTIVE. If holding reg empty: shift 0 instead and pulse underrun.
//   cpha=0: first bit placed on miso in same cycle as load. cpha=1: first bit on miso at first leading edge.
//  ACTIVE: miso_oe=1. Each sample edge shifts mosi into rx shift reg (MSB- or LSB-first per lsbfe) and increments bit count.
//   Each shift edge presents next tx bit. The cpha=1 first leading edge presents bit 0 and does not advance further.
//   Bit order: lsbfe=0 -> tx bit DATA_WIDTH-1 first, rx fills from MSB; lsbfe=1 -> bit 0 first.
//  Word complete at DATA_WIDTH-th sample edge: next cycle rx_data<=shift reg, rx_valid<=1, bit count wraps to 0.
//   If rx_valid already 1 (no ack): rx_data overwritten, overrun pulses.
//   If ss_n still low: next word reloads from holding reg at next word start (same underrun rule); continuous frames supported.
//  Simultaneous rx_ack and word complete: rx_valid stays 1 (new word wins); no overrun.
//  tx_load while tx_empty=0: overwrites holding reg (last write wins); tx_load in same cycle as load-to-shift: new data to holding reg, tx_empty=0.
//  ss_n 1 mid-word (synced): return to IDLE next cycle, miso_oe=0, miso=0; partial rx word discarded, no rx_valid.
//   Unconsumed holding reg retained.
//  Sclk edges with ss_n high are ignored.
// TESTING
//  Mode0 MSB-first, tx_load 0x3C, master sends 0xA5 -> master receives 0x3C; rx_data=0xA5, rx_valid=1, overrun=0.
//  Mode3 LSB-first, tx 0x81, master sends 0x01 -> miso bit order 1,0,0,0,0,0,0,1; rx_data=0x01.
//  ss_n released after 5 sclks (mode1) -> state IDLE, rx_valid=0, miso_oe=0; next full frame 0x5A received correctly.
//  Two-word frame (mode2), no rx_ack, no second tx_load -> underrun pulse at word 2 start, word 2 miso=0x00;
//   overrun pulse at word 2 end; rx_data = word 2.
//  PRESET asserted at bit 4 of a frame -> all outputs at reset values next cycle; frame after reset completes normally.
//  rx_ack coincident with word completion -> rx_valid=1 with new data, overrun=0.

Source files
------------

// File: rtl/spi_slave_shifter_if.sv
// SPI slave shifter bus bundle.
// Carries the SPI pad signals (sclk, ss_n, mosi, miso, miso_oe), the mode
// controls (cpol, cpha, lsbfe) and the word-level handshake towards the APB
// register block (tx_data/tx_load/tx_empty, rx_data/rx_valid/rx_ack,
// overrun/underrun/busy).
//   slave  modport : the shifter itself
//   master modport : the environment (pads + register block)
interface spi_slave_shifter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic                  cpol;
    logic                  cpha;
    logic                  lsbfe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic                  tx_empty;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ack;
    logic                  overrun;
    logic                  underrun;
    logic                  busy;

    modport slave (
        input  sclk, ss_n, mosi, cpol, cpha, lsbfe, tx_data, tx_load, rx_ack,
        output miso, miso_oe, tx_empty, rx_data, rx_valid, overrun, underrun, busy
    );

    modport master (
        output sclk, ss_n, mosi, cpol, cpha, lsbfe, tx_data, tx_load, rx_ack,
        input  miso, miso_oe, tx_empty, rx_data, rx_valid, overrun, underrun, busy
    );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI responder-side shifter.
// Oversamples sclk/ss_n/mosi in the PCLK domain, deserialises mosi into rx
// words and serialises tx words onto miso. All four CPOL/CPHA modes, MSB or
// LSB first. Requires PCLK >= 8x sclk.
// Ports:
//   PCLK    system clock, all logic on posedge
//   PRESET  synchronous active-high reset
//   spi     bus bundle (slave modport): pads, mode controls, tx/rx handshake
module spi_slave_shifter #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    spi_slave_shifter_if.slave   spi
);
    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int TCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);
    localparam logic [TCW-1:0] WORD_BITS = TCW'(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        head_bit = lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
        advance = lsb ? (w >> 1) : (w << 1);
    endfunction

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, ss_dly_q;

    // ss_n flops reset to 0 so that a select already low when PRESET drops
    // is not mistaken for a fresh frame start.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   spi.ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, ss_s, mosi_s;
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------- state
    state_t                  state_q;
    logic                    cpol_q, cpha_q, lsbfe_q;
    logic                    miso_q, miso_oe_q, busy_q;
    logic [DATA_WIDTH-1:0]   tx_sh_q, rx_sh_q, hold_q, rx_data_q;
    logic [TCW-1:0]          tx_cnt_q;
    logic [BCW-1:0]          bit_cnt_q;
    logic                    done_q, tx_empty_q, rx_valid_q, overrun_q, underrun_q;
    logic                    pend_q, pend_empty_q, fresh_q;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
    assign sclk_rise   = sclk_s & ~sclk_dly_q;
    assign sclk_fall   = ~sclk_s & sclk_dly_q;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge  : trail_edge;
    assign ss_fall     = ss_dly_q & ~ss_s;

    // Word source for a reload: empty holding reg sends zeros.
    logic [DATA_WIDTH-1:0] next_word;
    assign next_word = tx_empty_q ? '0 : hold_q;

    logic start_frame, active_ok, word_end_tx, take_now, peek, commit;
    assign start_frame = (state_q == IDLE) & ss_fall;
    assign active_ok   = (state_q == ACTIVE) & ~ss_s;
    assign word_end_tx = active_ok & shift_edge & (tx_cnt_q == WORD_BITS);
    // cpha=1: the shift edge that ends a word is the next word's leading
    // edge, so the reload is consumed right there.
    assign take_now    = start_frame | (word_end_tx & cpha_q);
    // cpha=0: the next word's first bit must sit on miso before its first
    // leading edge, so it is presented at the last trailing edge (peek) but
    // only consumed at that leading edge (commit). A frame that ends after
    // the last trailing edge therefore neither consumes the holding reg nor
    // flags underrun.
    assign peek        = word_end_tx & ~cpha_q;
    assign commit      = active_ok & sample_edge & pend_q;

    // ------------------------------------------------- tx holding register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            hold_q       <= '0;
            tx_empty_q   <= 1'b1;
            underrun_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_empty_q <= 1'b0;
            fresh_q      <= 1'b0;
        end else begin
            if (spi.tx_load) begin
                hold_q     <= spi.tx_data;
                tx_empty_q <= 1'b0;
            end else if (take_now | (commit & ~fresh_q)) begin
                tx_empty_q <= 1'b1;
            end
            underrun_q <= (take_now & tx_empty_q) | (commit & pend_empty_q);

            // fresh_q: holding reg rewritten after the peek, so the commit
            // must not mark it consumed.
            if (!active_ok) begin
                pend_q <= 1'b0;
            end else if (peek) begin
                pend_q       <= 1'b1;
                pend_empty_q <= tx_empty_q;
                fresh_q      <= spi.tx_load;
            end else if (commit) begin
                pend_q <= 1'b0;
            end else if (spi.tx_load) begin
                fresh_q <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------- FSM + shifters
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            tx_sh_q   <= '0;
            tx_cnt_q  <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q   <= ACTIVE;
                        miso_oe_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cpol_q    <= spi.cpol;
                        cpha_q    <= spi.cpha;
                        lsbfe_q   <= spi.lsbfe;
                        rx_sh_q   <= '0;
                        bit_cnt_q <= '0;
                        if (spi.cpha) begin
                            tx_sh_q  <= next_word;
                            tx_cnt_q <= '0;
                            miso_q   <= 1'b0;
                        end else begin
                            miso_q   <= head_bit(next_word, spi.lsbfe);
                            tx_sh_q  <= advance(next_word, spi.lsbfe);
                            tx_cnt_q <= TCW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_s) begin
                        // Deselect: drop partial word, release the pad.
                        state_q   <= IDLE;
                        miso_oe_q <= 1'b0;
                        miso_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        tx_cnt_q  <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh_q <= lsbfe_q ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                                               : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (tx_cnt_q == WORD_BITS) begin
                                miso_q   <= head_bit(next_word, lsbfe_q);
                                tx_sh_q  <= advance(next_word, lsbfe_q);
                                tx_cnt_q <= TCW'(1);
                            end else begin
                                miso_q   <= head_bit(tx_sh_q, lsbfe_q);
                                tx_sh_q  <= advance(tx_sh_q, lsbfe_q);
                                tx_cnt_q <= tx_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ rx hand-off
    // A completing word beats a same-cycle rx_ack and is not an overrun.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                rx_data_q  <= rx_sh_q;
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q & ~spi.rx_ack;
            end else if (spi.rx_ack) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign spi.miso     = miso_q;
    assign spi.miso_oe  = miso_oe_q;
    assign spi.busy     = busy_q;
    assign spi.tx_empty = tx_empty_q;
    assign spi.rx_data  = rx_data_q;
    assign spi.rx_valid = rx_valid_q;
    assign spi.overrun  = overrun_q;
    assign spi.underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: bus-functional SPI master plus scoreboard.
// Expected rx words and expected master-received miso words are queued when
// a frame is issued; monitors pop and compare as the DUT delivers them.
module tb_spi_slave_shifter;
    localparam int W    = 8;
    localparam int HALF = 80;   // sclk half period: 8 PCLKs

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;

    spi_slave_shifter_if #(.DATA_WIDTH(W)) bus();

    spi_slave_shifter #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .spi    (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [W-1:0] data;
        logic         ovr;
    } rx_exp_t;

    rx_exp_t      exp_rx_q[$];
    logic [W-1:0] exp_miso_q[$];
    logic [W-1:0] act_miso_q[$];
    int checks = 0;
    int errors = 0;
    int urun_cnt = 0;
    int orun_cnt = 0;
    logic         mon_pv = 1'b0;
    logic [W-1:0] mon_pd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // rx monitor: a delivery is rx_valid rising, an overrun, or new data.
    initial begin
        rx_exp_t e;
        forever begin
            @(negedge PCLK);
            if (bus.underrun) urun_cnt++;
            if (bus.overrun)  orun_cnt++;
            if (!PRESET && bus.rx_valid &&
                (!mon_pv || bus.overrun || bus.rx_data != mon_pd)) begin
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h want none", bus.rx_data);
                end else begin
                    e = exp_rx_q.pop_front();
                    chk("rx_data", bus.rx_data, e.data);
                    chk("rx_overrun", bus.overrun, e.ovr);
                end
            end
            mon_pv = bus.rx_valid;
            mon_pd = bus.rx_data;
        end
    end

    // miso monitor: compares words collected by the master model.
    initial begin
        logic [W-1:0] a;
        forever begin
            @(negedge PCLK);
            while (act_miso_q.size() > 0) begin
                a = act_miso_q.pop_front();
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got 0x%0h want none", a);
                end else begin
                    chk("miso_word", a, exp_miso_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic bit_of(input logic [W-1:0] w, input int k, input logic lsb);
        bit_of = lsb ? w[k] : w[W-1-k];
    endfunction

    function automatic logic [W-1:0] put_bit(input logic [W-1:0] w, input int k,
                                             input logic lsb, input logic b);
        logic [W-1:0] r;
        r = w;
        if (lsb) r[k] = b;
        else     r[W-1-k] = b;
        put_bit = r;
    endfunction

    // Half-period wait; optionally pulses rx_ack on the cycle the word is handed off.
    task automatic half_wait(input bit ack);
        if (ack) begin
            #30 bus.rx_ack = 1'b1;
            #10 bus.rx_ack = 1'b0;
            #(HALF - 40);
        end else begin
            #HALF;
        end
    endtask

    // SPI master: nwords words (w0, w1); stop_after>0 stops after that many
    // sclk cycles without collecting; keep_ss leaves ss_n low on return.
    task automatic xfer(input logic pol, input logic pha, input logic lsb, input int nwords,
                        input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input int stop_after, input bit keep_ss, input bit ack_last);
        logic [W-1:0] got;
        int nb;
        int last;
        nb   = nwords * W;
        last = (stop_after > 0) ? stop_after : nb;
        got  = '0;
        bus.cpol = pol; bus.cpha = pha; bus.lsbfe = lsb; bus.sclk = pol;
        @(negedge PCLK);
        #40;
        bus.ss_n = 1'b0;
        if (!pha) bus.mosi = bit_of(w0, 0, lsb);
        #HALF;
        for (int i = 0; i < last; i++) begin
            int bi;
            bi = i % W;
            bus.sclk = ~pol;
            if (pha) bus.mosi = bit_of((i < W) ? w0 : w1, bi, lsb);
            else     got = put_bit(got, bi, lsb, bus.miso);
            half_wait(!pha && ack_last && i == nb - 1);
            bus.sclk = pol;
            if (pha) got = put_bit(got, bi, lsb, bus.miso);
            else if (i + 1 < nb) bus.mosi = bit_of((i + 1 < W) ? w0 : w1, (i + 1) % W, lsb);
            if (stop_after == 0 && bi == W - 1) act_miso_q.push_back(got);
            half_wait(pha && ack_last && i == nb - 1);
        end
        if (!keep_ss) bus.ss_n = 1'b1;
        #200;
    endtask

    task automatic load(input logic [W-1:0] v);
        @(negedge PCLK);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        @(negedge PCLK);
        bus.tx_load = 1'b0;
    endtask

    task automatic ack();
        @(negedge PCLK);
        bus.rx_ack = 1'b1;
        @(negedge PCLK);
        bus.rx_ack = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic expect_rx(input logic [W-1:0] d, input logic o);
        rx_exp_t e;
        e.data = d;
        e.ovr  = o;
        exp_rx_q.push_back(e);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_miso"},     bus.miso,     0);
        chk({tag, "_miso_oe"},  bus.miso_oe,  0);
        chk({tag, "_tx_empty"}, bus.tx_empty, 1);
        chk({tag, "_rx_data"},  bus.rx_data,  0);
        chk({tag, "_rx_valid"}, bus.rx_valid, 0);
        chk({tag, "_overrun"},  bus.overrun,  0);
        chk({tag, "_underrun"}, bus.underrun, 0);
        chk({tag, "_busy"},     bus.busy,     0);
    endtask

    initial begin
        int u0;
        int o0;
        bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsbfe = 1'b0;
        bus.tx_data = '0; bus.tx_load = 1'b0; bus.rx_ack = 1'b0;
        repeat (3) @(negedge PCLK);
        reset_check("rst");
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);

        // Mode 0, MSB first; second load overwrites the first.
        u0 = urun_cnt;
        load(8'hAA);
        load(8'h3C);
        chk("t1_tx_empty_loaded", bus.tx_empty, 0);
        exp_miso_q.push_back(8'h3C);
        expect_rx(8'hA5, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1, 8'hA5, 8'h00, 0, 1'b0, 1'b0);
        chk("t1_tx_empty_after", bus.tx_empty, 1);
        chk("t1_rx_valid", bus.rx_valid, 1);
        chk("t1_underrun_cnt", urun_cnt - u0, 0);
        ack();
        chk("t1_rx_valid_acked", bus.rx_valid, 0);

        // Mode 3, LSB first: miso bits 1,0,0,0,0,0,0,1.
        load(8'h81);
        exp_miso_q.push_back(8'h81);
        expect_rx(8'h01, 1'b0);
        xfer(1'b1, 1'b1, 1'b1, 1, 8'h01, 8'h00, 0, 1'b0, 1'b0);
        ack();

        // Mode 1, deselect after 5 sclks, then a full frame.
        u0 = urun_cnt;
        load(8'h77);
        xfer(1'b0, 1'b1, 1'b0, 1, 8'h33, 8'h00, 5, 1'b0, 1'b0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_miso_oe", bus.miso_oe, 0);
        chk("t3_miso", bus.miso, 0);
        chk("t3_rx_valid", bus.rx_valid, 0);
        chk("t3_tx_empty", bus.tx_empty, 1);
        load(8'hC3);
        exp_miso_q.push_back(8'hC3);
        expect_rx(8'h5A, 1'b0);
        xfer(1'b0, 1'b1, 1'b0, 1, 8'h5A, 8'h00, 0, 1'b0, 1'b0);
        chk("t3_underrun_cnt", urun_cnt - u0, 0);
        ack();

        // Mode 2, two words, one load, no ack: underrun then overrun.
        u0 = urun_cnt;
        o0 = orun_cnt;
        load(8'h96);
        exp_miso_q.push_back(8'h96);
        exp_miso_q.push_back(8'h00);
        expect_rx(8'h11, 1'b0);
        expect_rx(8'h22, 1'b1);
        xfer(1'b1, 1'b0, 1'b0, 2, 8'h11, 8'h22, 0, 1'b0, 1'b0);
        chk("t4_underrun_cnt", urun_cnt - u0, 1);
        chk("t4_overrun_cnt", orun_cnt - o0, 1);
        chk("t4_rx_data", bus.rx_data, 8'h22);

        // PRESET during bit 4 of a mode 0 frame.
        xfer(1'b0, 1'b0, 1'b0, 1, 8'hF0, 8'h00, 4, 1'b1, 1'b0);
        load(8'h5A);
        chk("t5_busy_pre", bus.busy, 1);
        chk("t5_tx_empty_pre", bus.tx_empty, 0);
        chk("t5_rx_valid_pre", bus.rx_valid, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        reset_check("t5");
        PRESET = 1'b0;
        bus.ss_n = 1'b1;
        repeat (10) @(negedge PCLK);
        load(8'hE7);
        exp_miso_q.push_back(8'hE7);
        expect_rx(8'h3C, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 0, 1'b0, 1'b0);

        // rx_ack coincident with word completion, previous word unread.
        o0 = orun_cnt;
        load(8'h42);
        exp_miso_q.push_back(8'h42);
        expect_rx(8'h99, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1, 8'h99, 8'h00, 0, 1'b0, 1'b1);
        chk("t6_rx_valid", bus.rx_valid, 1);
        chk("t6_overrun_cnt", orun_cnt - o0, 0);

        repeat (5) @(negedge PCLK);
        chk("rx_queue_left", exp_rx_q.size(), 0);
        chk("miso_queue_left", exp_miso_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
